// File: rtl/mem_pkg.sv
// Shared types for the MEM/WB stage: handshake FSM states and
// writeback-control bit positions.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hs_state_e;

    typedef enum int {
        WB_HALT     = 0,
        WB_PCTOREG  = 1,
        WB_MEMTOREG = 2,
        WB_REGWRITE = 3
    } wb_bit_e;

    function automatic logic wb_is_load(
        input logic [3:0] ctrl,
        input logic       noop
    );
        return ctrl[WB_REGWRITE] & ctrl[WB_MEMTOREG] & ~noop;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage and memory.
interface mem_wb_stage_if #(
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/dmem_hs_fsm.sv
// Data-memory handshake: IDLE/BUSY FSM, request latches, wait counter,
// stall generation and sticky timeout flag.
module dmem_hs_fsm
    import mem_pkg::*;
#(
    parameter int DW       = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_i,
    input  logic          we_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          ready_i,
    output logic          req_o,
    output logic          we_o,
    output logic [DW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          stall_o,
    output logic          abort_o,
    output logic          err_o
);
    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    hs_state_e     state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          req_raw, stall_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        err_d     = err_q;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        abort_o   = 1'b0;
        we_o      = we_i;
        addr_o    = addr_i;
        wdata_o   = wdata_i;
        unique case (state_q)
            IDLE: begin
                req_raw = op_i;
                if (op_i && !ready_i) begin
                    stall_raw = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    we_d      = we_i;
                end
            end
            BUSY: begin
                we_o    = we_q;
                addr_o  = addr_q;
                wdata_o = wdata_q;
                if (ready_i) begin
                    req_raw = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MAX_W) begin
                    // give up: upstream moves on and the op is dropped
                    abort_o = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    req_raw   = 1'b1;
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
        endcase
    end

    assign req_o   = req_raw & ~rst;
    assign stall_o = stall_raw & ~rst;
    assign err_o   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: memory handshake, byte extract, bubbles.
// Optional MEM2MEM_FWD_EN forwards a just-loaded value into a store.
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RW       = 4,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_write_i,
    input  logic          mem_read_i,
    input  logic [3:0]    wb_ctrl_i,
    input  logic [DW-1:0] alu_data_i,
    input  logic [DW-1:0] store_data_i,
    input  logic [RW-1:0] dst_reg_i,
    input  logic [RW-1:0] src_reg2_i,
    input  logic [DW-1:0] pc_i,
    input  logic          lb_ins_i,
    input  logic          is_noop_i,
    mem_wb_stage_if.master dmem,
    output logic          mem_stall_o,
    output logic          dmem_err_o,
    output logic [3:0]    wb_ctrl_o,
    output logic [DW-1:0] mem_data_o,
    output logic [DW-1:0] alu_data_o,
    output logic [RW-1:0] dst_reg_o,
    output logic [DW-1:0] pc_o,
    output logic          is_noop_o
);
    logic [3:0]    wb_ctrl_q, wb_ctrl_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [DW-1:0] alu_data_q, alu_data_d;
    logic [RW-1:0] dst_reg_q, dst_reg_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          is_noop_q, is_noop_d;

    logic          op_valid, is_load, capture, abort;
    logic          req, we;
    logic [DW-1:0] addr, wdata, wdata_in, rdata_ext;

    assign op_valid = (mem_read_i | mem_write_i) & ~is_noop_i;
    assign is_load  = op_valid & ~mem_write_i;

`ifdef MEM2MEM_FWD_EN
    logic fwd;
    assign fwd = wb_is_load(wb_ctrl_q, is_noop_q) & op_valid & mem_write_i
               & (src_reg2_i == dst_reg_q) & (dst_reg_q != '0);
    assign wdata_in = fwd ? mem_data_q : store_data_i;
`else
    logic unused_src2;
    assign unused_src2 = ^src_reg2_i;
    assign wdata_in    = store_data_i;
`endif

    dmem_hs_fsm #(
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .op_i    (op_valid),
        .we_i    (mem_write_i),
        .addr_i  (alu_data_i),
        .wdata_i (wdata_in),
        .ready_i (dmem.ready),
        .req_o   (req),
        .we_o    (we),
        .addr_o  (addr),
        .wdata_o (wdata),
        .stall_o (mem_stall_o),
        .abort_o (abort),
        .err_o   (dmem_err_o)
    );

    assign dmem.req   = req;
    assign dmem.we    = we;
    assign dmem.addr  = addr;
    assign dmem.wdata = wdata;

    assign rdata_ext = lb_ins_i ? {{(DW-8){1'b0}}, dmem.rdata[7:0]}
                                : dmem.rdata;
    assign capture   = ~mem_stall_o & ~abort;

    always_comb begin
        wb_ctrl_d  = '0;
        mem_data_d = '0;
        alu_data_d = '0;
        dst_reg_d  = '0;
        pc_d       = '0;
        is_noop_d  = 1'b1;
        if (capture) begin
            wb_ctrl_d  = wb_ctrl_i;
            mem_data_d = is_load ? rdata_ext : '0;
            alu_data_d = alu_data_i;
            dst_reg_d  = dst_reg_i;
            pc_d       = pc_i;
            is_noop_d  = is_noop_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctrl_q  <= '0;
            mem_data_q <= '0;
            alu_data_q <= '0;
            dst_reg_q  <= '0;
            pc_q       <= '0;
            is_noop_q  <= 1'b1;
        end else begin
            wb_ctrl_q  <= wb_ctrl_d;
            mem_data_q <= mem_data_d;
            alu_data_q <= alu_data_d;
            dst_reg_q  <= dst_reg_d;
            pc_q       <= pc_d;
            is_noop_q  <= is_noop_d;
        end
    end

    assign wb_ctrl_o  = wb_ctrl_q;
    assign mem_data_o = mem_data_q;
    assign alu_data_o = alu_data_q;
    assign dst_reg_o  = dst_reg_q;
    assign pc_o       = pc_q;
    assign is_noop_o  = is_noop_q;
endmodule
